// File: rtl/testeio_pio_pkg.sv
// Shared constants for the testeio PIO/GPIO slave: bus widths, register map and edge-select codes.
package testeio_pio_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_MASK    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CAPTURE = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/testeio_pio_sync_edge.sv
// Pin synchroniser (s1/s2/s3), post-reset arm counter and per-bit edge event generation.
module testeio_pio_sync_edge
    import testeio_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_i,
    input  logic [WIDTH-1:0] dir_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] ev_o
);

    logic [WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [1:0]       arm_cnt_q, arm_cnt_d;
    logic             armed;
    logic [WIDTH-1:0] edge_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            arm_cnt_q <= 2'd0;
        end else begin
            s1_q      <= pin_i;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    // Hold off events until s3 has seen real pin data, so high pins after reset are not edges.
    assign armed = (arm_cnt_q == 2'd3);

    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (!armed) begin
            arm_cnt_d = arm_cnt_q + 2'd1;
        end
    end

    always_comb begin
        edge_sel = s2_q & ~s3_q;
        case (EDGE_TYPE)
            EDGE_FALL: edge_sel = ~s2_q & s3_q;
            EDGE_ANY:  edge_sel = s2_q ^ s3_q;
            default:   edge_sel = s2_q & ~s3_q;
        endcase
    end

    assign ev_o   = edge_sel & ~dir_i & {WIDTH{armed}};
    assign sync_o = s2_q;

endmodule

// File: rtl/testeio_pio_gpio.sv
// Avalon-MM GPIO slave: per-bit direction, atomic set/clear, edge capture and masked level irq.
module testeio_pio_gpio
    import testeio_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic [WIDTH-1:0]  oe,
    output logic              irq
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] rd_c;
    logic             wr_en;
    logic             wd_unused_c;

    assign wr_en       = chipselect & ~write_n;
    assign wd          = writedata[WIDTH-1:0];
    assign wd_unused_c = ^writedata;

    testeio_pio_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_i   (in_port),
        .dir_i   (dir_q),
        .sync_o  (sync_in),
        .ev_o    (ev)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            dir_q  <= DIR_RESET;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    // Register writes; a new event is OR-ed in after the clear so it survives a same-cycle W1C.
    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:    data_d = wd;
                ADDR_DIR:     dir_d  = wd;
                ADDR_MASK:    mask_d = wd;
                ADDR_CAPTURE: cap_d  = cap_q & ~wd;
                ADDR_OUTSET:  data_d = data_q | wd;
                ADDR_OUTCLR:  data_d = data_q & ~wd;
                default:      ;
            endcase
        end
        cap_d = cap_d | ev;
    end

    // DATA reads drive-back for outputs and synchronised pins for inputs.
    always_comb begin
        rd_c = '0;
        case (address)
            ADDR_DATA:    rd_c = (data_q & dir_q) | (sync_in & ~dir_q);
            ADDR_DIR:     rd_c = dir_q;
            ADDR_MASK:    rd_c = mask_q;
            ADDR_CAPTURE: rd_c = cap_q;
            default:      rd_c = '0;
        endcase
    end

    assign readdata = BUS_W'(rd_c);
    assign out_port = data_q;
    assign oe       = dir_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_testeio_pio_gpio.sv
// Scoreboard bench for testeio_pio_gpio: rising-edge and any-edge instances share the bus and pins.
module tb_testeio_pio_gpio;

    typedef enum int {K_RD0, K_RD2, K_OUT0, K_OE0, K_OUT2, K_OE2, K_IRQ0, K_IRQ2} kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd2;
    logic [7:0]  out0, out2, oe0, oe2;
    logic        irq0, irq2;

    item_t sb[$];
    int    total;
    int    bad;

    testeio_pio_gpio #(
        .WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'h0F), .EDGE_TYPE(0)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port),
        .out_port(out0), .oe(oe0), .irq(irq0)
    );

    testeio_pio_gpio #(
        .WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'h0F), .EDGE_TYPE(2)
    ) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port),
        .out_port(out2), .oe(oe2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every queued expectation is resolved at the next falling edge.
    always @(negedge clk) begin
        item_t       it;
        logic [31:0] act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.kind)
                K_RD0:   act = rd0;
                K_RD2:   act = rd2;
                K_OUT0:  act = 32'(out0);
                K_OE0:   act = 32'(oe0);
                K_OUT2:  act = 32'(out2);
                K_OE2:   act = 32'(oe2);
                K_IRQ0:  act = 32'(irq0);
                default: act = 32'(irq2);
            endcase
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h (t=%0t)", it.name, act, it.exp, $time);
            end
        end
    end

    task automatic expect_v(input kind_t k, input logic [31:0] e, input string nm);
        item_t it;
        it.kind = k;
        it.exp  = e;
        it.name = nm;
        sb.push_back(it);
    endtask

    task automatic expect_rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        address = a;
        expect_v(K_RD0, e, {nm, "/rise"});
        expect_v(K_RD2, e, {nm, "/any"});
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hFF;

        // Reset values with all pins high
        repeat (2) @(posedge clk);
        #1;
        expect_v(K_OUT0, 32'hA5, "rst_out");
        expect_v(K_OE0,  32'h0F, "rst_oe");
        expect_v(K_OUT2, 32'hA5, "rst_out2");
        expect_v(K_OE2,  32'h0F, "rst_oe2");
        expect_v(K_IRQ0, 32'h0,  "rst_irq");
        sample();
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        expect_rd(3'd3, 32'h00, "arm_cap");
        sample();
        expect_rd(3'd0, 32'hF5, "arm_data");
        sample();

        // DATA / OUTSET / OUTCLR, upper writedata bits ignored
        wr(3'd0, 32'hFFFF_FF3C);
        expect_v(K_OUT0, 32'h3C, "data_wr");
        sample();
        wr(3'd4, 32'h0000_0081);
        expect_v(K_OUT0, 32'hBD, "outset");
        sample();
        wr(3'd5, 32'h0000_000C);
        expect_v(K_OUT0, 32'hB1, "outclr");
        expect_rd(3'd4, 32'h0, "outset_rd");
        sample();
        expect_rd(3'd5, 32'h0, "outclr_rd");
        sample();
        expect_rd(3'd0, 32'hF1, "data_mix_rd");
        sample();

        // Rising edge on bit2, exact latency
        wr(3'd1, 32'h00);
        wr(3'd2, 32'h04);
        in_port = 8'hFB;
        repeat (5) @(posedge clk);
        #1;
        wr(3'd3, 32'hFF);
        in_port = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_v(K_IRQ0, 32'h0, "e2_irq");
        expect_rd(3'd3, 32'h00, "e2_cap");
        sample();
        @(posedge clk);
        #1;
        expect_v(K_IRQ0, 32'h1, "e3_irq");
        expect_v(K_IRQ2, 32'h1, "e3_irq2");
        expect_rd(3'd3, 32'h04, "e3_cap");
        sample();
        in_port = 8'hFB;
        repeat (5) @(posedge clk);
        #1;
        expect_rd(3'd3, 32'h04, "fall_cap");
        sample();

        // W1C colliding with a new event on the same bit
        in_port = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        wr(3'd3, 32'h04);
        expect_v(K_IRQ0, 32'h1, "clr_hit_irq");
        expect_v(K_IRQ2, 32'h1, "clr_hit_irq2");
        expect_rd(3'd3, 32'h04, "clr_hit_cap");
        sample();
        wr(3'd3, 32'h04);
        expect_v(K_IRQ0, 32'h0, "clr_irq");
        expect_v(K_IRQ2, 32'h0, "clr_irq2");
        expect_rd(3'd3, 32'h00, "clr_cap");
        sample();

        // Output bits never capture; input bits do; mask gates irq only
        wr(3'd1, 32'h20);
        wr(3'd2, 32'h20);
        in_port = 8'hDF;
        repeat (5) @(posedge clk);
        #1;
        expect_v(K_IRQ2, 32'h0, "outdir_irq2");
        expect_rd(3'd3, 32'h00, "outdir_cap");
        sample();
        wr(3'd1, 32'h00);
        in_port = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        expect_v(K_IRQ2, 32'h1, "indir_irq2");
        expect_rd(3'd3, 32'h20, "indir_cap");
        sample();
        expect_rd(3'd0, 32'hFF, "data_in_rd");
        sample();
        wr(3'd2, 32'h00);
        expect_v(K_IRQ0, 32'h0, "mask0_irq");
        expect_v(K_IRQ2, 32'h0, "mask0_irq2");
        expect_rd(3'd3, 32'h20, "mask0_cap");
        sample();

        // Fill capture, then asynchronous reset mid-cycle
        in_port = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        in_port = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        wr(3'd0, 32'h55);
        wr(3'd2, 32'hFF);
        expect_v(K_OUT0, 32'h55, "pre_out");
        expect_v(K_IRQ0, 32'h1,  "pre_irq");
        expect_v(K_IRQ2, 32'h1,  "pre_irq2");
        expect_rd(3'd3, 32'hFF, "pre_cap");
        sample();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        expect_v(K_OUT0, 32'hA5, "arst_out");
        expect_v(K_OE0,  32'h0F, "arst_oe");
        expect_v(K_IRQ0, 32'h0,  "arst_irq");
        expect_v(K_IRQ2, 32'h0,  "arst_irq2");
        expect_rd(3'd3, 32'h00, "arst_cap");
        sample();
        expect_rd(3'd2, 32'h00, "arst_mask");
        sample();
        expect_rd(3'd1, 32'h0F, "arst_dir");
        sample();
        expect_rd(3'd0, 32'h05, "arst_data");
        sample();
        expect_rd(3'd6, 32'h0, "addr6");
        sample();
        expect_rd(3'd7, 32'h0, "addr7");
        sample();
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        expect_rd(3'd3, 32'h00, "rearm_cap");
        sample();
        expect_rd(3'd0, 32'hF5, "rearm_data");
        sample();

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
